// File: rtl/audio_pkg.sv
// Types and widths shared by the codec capture (ADC) and playback (DAC) paths.
package audio_pkg;

  localparam int AUDIO_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ALIGN,
    DELAY,
    SHIFT,
    HOLD
  } rx_state_t;

  typedef enum logic {
    CH_L,
    CH_R
  } ch_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous codec line, with one-Clk
// rise/fall strobes derived from the synchronized level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= STAGES'({sync_q, d_i});
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Strobes are taken from the last synchronizer stage so that data sampled
  // from the same stage lines up with them.
  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S ADC capture: brings the codec serial stream onto Clk and delivers
// left/right sample pairs through a valid/ready handshake.
//
// state | meaning
// ALIGN | wait for an LRCK fall (start of a left word)
// DELAY | skip the one-bit I2S delay after an LRCK edge
// SHIFT | shift data bits in MSB first
// HOLD  | word latched, ignore extra slot bits until the next LRCK edge
module i2s_adc_receiver
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] LDATA_OUT,
  output logic [DATA_WIDTH-1:0] RDATA_OUT,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  logic bclk_sync, bclk_rise, bclk_fall;
  logic lrck_sync, lrck_rise, lrck_fall;
  logic dat_sync, dat_rise, dat_fall;
  logic unused_taps;

  sync_edge #(.STAGES(SYNC_STAGES)) u_bclk (
    .clk_i  (Clk),
    .rst_n_i(Reset),
    .d_i    (AUD_BCLK),
    .sync_o (bclk_sync),
    .rise_o (bclk_rise),
    .fall_o (bclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_lrck (
    .clk_i  (Clk),
    .rst_n_i(Reset),
    .d_i    (AUD_ADCLRCK),
    .sync_o (lrck_sync),
    .rise_o (lrck_rise),
    .fall_o (lrck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_dat (
    .clk_i  (Clk),
    .rst_n_i(Reset),
    .d_i    (AUD_ADCDAT),
    .sync_o (dat_sync),
    .rise_o (dat_rise),
    .fall_o (dat_fall)
  );

  // Synchronizer taps the receiver has no use for.
  assign unused_taps = ^{bclk_sync, bclk_fall, lrck_sync, dat_rise, dat_fall};

  rx_state_t             state_q, state_d;
  ch_t                   ch_q, ch_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  left_seen_q, left_seen_d;
  logic                  pair_done_q, pair_done_d;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word_val;
  logic                  lrck_edge;
  ch_t                   lrck_ch;

  assign lrck_edge = lrck_rise | lrck_fall;
  assign lrck_ch   = lrck_rise ? CH_R : CH_L;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ALIGN;
      ch_q        <= CH_L;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_q      <= '0;
      right_q     <= '0;
      left_seen_q <= 1'b0;
      pair_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      right_q     <= right_d;
      left_seen_q <= left_seen_d;
      pair_done_q <= pair_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_d      = left_q;
    right_d     = right_q;
    left_seen_d = left_seen_q;
    pair_done_d = 1'b0;
    word_done   = 1'b0;
    word_val    = '0;

    unique case (state_q)
      ALIGN: begin
        if (lrck_fall) begin
          state_d = DELAY;
          ch_d    = CH_L;
        end
      end
      DELAY: begin
        if (lrck_edge) begin
          ch_d = lrck_ch;
        end else if (bclk_rise) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      SHIFT: begin
        // An LRCK edge wins over a coincident bit: the word ends short and
        // is left-aligned with zeroed LSBs.
        if (lrck_edge) begin
          word_done = 1'b1;
          word_val  = shift_q << (CNT_FULL - bit_cnt_q);
          state_d   = DELAY;
          ch_d      = lrck_ch;
        end else if (bclk_rise) begin
          shift_d   = {shift_q[DATA_WIDTH-2:0], dat_sync};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_LAST) begin
            word_done = 1'b1;
            word_val  = {shift_q[DATA_WIDTH-2:0], dat_sync};
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (lrck_edge) begin
          state_d = DELAY;
          ch_d    = lrck_ch;
        end
      end
      default: state_d = ALIGN;
    endcase

    if (word_done) begin
      if (ch_q == CH_L) begin
        left_d      = word_val;
        left_seen_d = 1'b1;
      end else if (left_seen_q) begin
        right_d     = word_val;
        pair_done_d = 1'b1;
      end
    end
  end

  logic [DATA_WIDTH-1:0] ldata_q, ldata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  accept;
  logic                  overrun_set;

  assign accept = valid_q & sample_ready;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ldata_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ldata_q   <= ldata_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    ldata_d     = ldata_q;
    rdata_d     = rdata_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;

    if (pair_done_q) begin
      if (!valid_q || accept) begin
        ldata_d = left_q;
        rdata_d = right_q;
        valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end

    // A fresh drop outranks a clear arriving in the same cycle.
    overrun_d = overrun_set | (overrun_q & ~overrun_clr);
  end

  assign LDATA_OUT    = ldata_q;
  assign RDATA_OUT    = rdata_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Bench for i2s_adc_receiver: behavioural I2S codec model, expected-pair
// queue filled at send time, and a handshake monitor that drains it.
module tb_i2s_adc_receiver;

  localparam int W = 16;
  localparam int S = 2;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         AUD_BCLK = 1'b0;
  logic         AUD_ADCLRCK = 1'b1;
  logic         AUD_ADCDAT = 1'b0;
  logic         sample_ready = 1'b0;
  logic         overrun_clr = 1'b0;
  logic [W-1:0] LDATA_OUT;
  logic [W-1:0] RDATA_OUT;
  logic         sample_valid;
  logic         overrun;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  event        ev_last_r;
  bit          jitter = 1'b0;
  int          half_nom = 160;
  int          lat;

  i2s_adc_receiver #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .LDATA_OUT   (LDATA_OUT),
    .RDATA_OUT   (RDATA_OUT),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #10 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Captured word: the first W data bits after the delay bit, MSB first,
  // zero-filled when the slot carries fewer than W data bits.
  function automatic logic [W-1:0] exp_word(input logic [31:0] bits, input int nslot);
    int           n;
    logic [W-1:0] w;
    n = nslot - 1;
    if (n > W) n = W;
    w = bits[31:32-W];
    for (int i = 0; i < W - n; i++) w[i] = 1'b0;
    return w;
  endfunction

  task automatic bit_period(input logic lr, input logic d, input bit fire);
    int h1, h2;
    h1 = jitter ? int'($urandom_range(43, 53)) : half_nom;
    h2 = jitter ? int'($urandom_range(43, 53)) : half_nom;
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    #(h1);
    AUD_BCLK = 1'b1;
    if (fire) -> ev_last_r;
    #(h2);
  endtask

  // One channel slot: a junk delay bit, then bits[31] onward, junk after bit 0.
  task automatic send_slot(input logic lr, input logic [31:0] bits, input int nslot);
    bit_period(lr, 1'($urandom), 1'b0);
    for (int i = 1; i < nslot; i++)
      bit_period(lr, bits[32-i], lr && (i == W));
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r,
                           input int nl, input int nr, input bit push);
    if (push) exp_q.push_back({exp_word(l, nl), exp_word(r, nr)});
    if (!jitter) @(negedge Clk);
    send_slot(1'b0, l, nl);
    send_slot(1'b1, r, nr);
  endtask

  always @(negedge Clk) begin
    if (Reset && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pair: got %h, expected no pair (t=%0t)", {LDATA_OUT, RDATA_OUT}, $time);
      end else begin
        check("pair", {LDATA_OUT, RDATA_OUT}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached with %0d pairs outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p1l, p1r, p2l, p2r, p3l, p3r, q2l, q2r;

    sample_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_ldata", 32'(LDATA_OUT), 32'h0);
    check("rst_rdata", 32'(RDATA_OUT), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    Reset = 1'b1;

    // LRCK starts high so the first left slot presents a falling edge.
    @(negedge Clk);
    send_slot(1'b1, $urandom, 32);

    // Basic pair and output latency from the last right bit.
    fork
      send_pair({16'hA55A, 16'($urandom)}, {16'h1234, 16'($urandom)}, 32, 32, 1'b1);
      begin
        @(ev_last_r);
        lat = 0;
        while (lat < 20 && !sample_valid) begin
          @(posedge Clk);
          #1;
          lat++;
        end
        check("latency", 32'(lat), 32'(S + 2));
      end
    join
    check("single_pulse", 32'(sample_valid), 32'h0);
    check("drain_basic", 32'(exp_q.size()), 32'h0);

    // Reset held through a frame, released mid right word.
    Reset = 1'b0;
    fork
      send_pair($urandom, $urandom, 32, 32, 1'b0);
      begin
        repeat (32 + 16) @(posedge AUD_BCLK);
        Reset = 1'b1;
      end
    join
    check("rst_mid_valid", 32'(sample_valid), 32'h0);
    check("rst_mid_data", {LDATA_OUT, RDATA_OUT}, 32'h0);
    send_pair({16'h0001, 16'($urandom)}, {16'h0002, 16'($urandom)}, 32, 32, 1'b1);
    send_pair({16'h7FFF, 16'($urandom)}, {16'h8000, 16'($urandom)}, 32, 32, 1'b1);
    check("drain_reset", 32'(exp_q.size()), 32'h0);

    // Consumer stalled: first pair held, later pairs dropped.
    sample_ready = 1'b0;
    p1l = $urandom; p1r = $urandom; p2l = $urandom; p2r = $urandom;
    p3l = $urandom; p3r = $urandom;
    send_pair(p1l, p1r, 32, 32, 1'b1);
    check("stall_valid", 32'(sample_valid), 32'h1);
    check("ovr_first", 32'(overrun), 32'h0);
    send_pair(p2l, p2r, 32, 32, 1'b0);
    check("ovr_second", 32'(overrun), 32'h1);
    check("held_pair", {LDATA_OUT, RDATA_OUT}, {exp_word(p1l, 32), exp_word(p1r, 32)});
    @(posedge Clk); #3 overrun_clr = 1'b1;
    @(posedge Clk); #3 overrun_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'h0);
    fork
      send_pair(p3l, p3r, 32, 32, 1'b0);
      begin
        @(ev_last_r);
        #53 overrun_clr = 1'b1;
        #20 overrun_clr = 1'b0;
      end
    join
    check("ovr_clr_collide", 32'(overrun), 32'h1);
    check("held_pair3", {LDATA_OUT, RDATA_OUT}, {exp_word(p1l, 32), exp_word(p1r, 32)});
    @(posedge Clk); #3 overrun_clr = 1'b1;
    @(posedge Clk); #3 overrun_clr = 1'b0;
    check("ovr_clr2", 32'(overrun), 32'h0);
    @(posedge Clk); #3 sample_ready = 1'b1;
    @(posedge Clk); #1;
    check("valid_drop", 32'(sample_valid), 32'h0);

    // Acceptance in the exact completion cycle.
    sample_ready = 1'b0;
    q2l = $urandom; q2r = $urandom;
    send_pair($urandom, $urandom, 32, 32, 1'b1);
    fork
      send_pair(q2l, q2r, 32, 32, 1'b1);
      begin
        @(ev_last_r);
        #53 sample_ready = 1'b1;
        #20 sample_ready = 1'b0;
        #2;
        check("coinc_valid", 32'(sample_valid), 32'h1);
        check("coinc_data", {LDATA_OUT, RDATA_OUT}, {exp_word(q2l, 32), exp_word(q2r, 32)});
        check("coinc_overrun", 32'(overrun), 32'h0);
      end
    join
    @(posedge Clk); #3 sample_ready = 1'b1;

    // 12-bit slots: words zero-filled; completes at the next LRCK fall.
    send_pair({12'hABC, 20'($urandom)}, {12'h123, 20'($urandom)}, 13, 13, 1'b1);

    // Random data, slot lengths, BCLK phase and jitter.
    jitter = 1'b1;
    #($urandom_range(1, 19));
    for (int k = 0; k < 200; k++)
      send_pair($urandom, $urandom, int'($urandom_range(9, 24)),
                int'($urandom_range(9, 24)), 1'b1);
    send_slot(1'b0, $urandom, 17);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge Clk);
    #1;
    check("drain_random", 32'(exp_q.size()), 32'h0);
    check("no_spurious_ovr", 32'(overrun), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
